// File: rtl/pcid_tlb.sv
// pcid_tlb: PCID-tagged, set-associative TLB with tree-PLRU replacement,
// global pages, selective invalidation and saturating hit/miss statistics.
//
// Ports:
//   clk, shutdown_n          clock; asynchronous active-low reset
//   ready / busy             request acceptance / PCID invalidation walk active
//   lookup_valid/va/pcid     lookup request (accepted when ready)
//   resp_valid/hit/pa        registered lookup response, one cycle after accept
//   insert_valid/va/pa/pcid/global   refill from the page walker
//   inv_valid/mode/va/pcid   invalidation (00 all, 01 PCID walk, 10 VA+PCID, 11 VA)
//   hit_cnt, miss_cnt        saturating lookup counters
module pcid_tlb #(
    parameter int SADDR = 64,
    parameter int SPAGE = 12,
    parameter int NSET  = 8,
    parameter int NWAY  = 8,
    parameter int SPCID = 12,
    parameter int SCNT  = 32
) (
    input  logic             clk,
    input  logic             shutdown_n,
    output logic             ready,
    input  logic             lookup_valid,
    input  logic [SADDR-1:0] lookup_va,
    input  logic [SPCID-1:0] lookup_pcid,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [SADDR-1:0] resp_pa,
    input  logic             insert_valid,
    input  logic [SADDR-1:0] insert_va,
    input  logic [SADDR-1:0] insert_pa,
    input  logic [SPCID-1:0] insert_pcid,
    input  logic             insert_global,
    input  logic             inv_valid,
    input  logic [1:0]       inv_mode,
    input  logic [SADDR-1:0] inv_va,
    input  logic [SPCID-1:0] inv_pcid,
    output logic             busy,
    output logic [SCNT-1:0]  hit_cnt,
    output logic [SCNT-1:0]  miss_cnt
);
    localparam int SETW = $clog2(NSET);
    localparam int WAYW = $clog2(NWAY);
    localparam int SVPN = SADDR - SPAGE;
    localparam int STAG = SVPN - SETW;

    typedef enum logic {IDLE, WALK} state_t;

    // Entry storage. PLRU node n (heap order, 1..NWAY-1) lives in bit n; bit 0 is spare.
    logic [NWAY-1:0]  valid_q [NSET];
    logic [NWAY-1:0]  glob_q  [NSET];
    logic [NWAY-1:0]  plru_q  [NSET];
    logic [SPCID-1:0] pcid_q  [NSET][NWAY];
    logic [STAG-1:0]  tag_q   [NSET][NWAY];
    logic [SVPN-1:0]  ppn_q   [NSET][NWAY];

    state_t           state_q, state_d;
    logic [SETW-1:0]  walk_cnt_q, walk_cnt_d;
    logic [SPCID-1:0] walk_pcid_q;

    // Tree node bit points toward the less recently used half.
    function automatic logic [NWAY-1:0] plru_touch(input logic [NWAY-1:0] tree,
                                                   input logic [WAYW-1:0] way);
        logic [NWAY-1:0] t;
        logic [WAYW-1:0] node;
        t    = tree;
        node = WAYW'(1);
        for (int l = WAYW - 1; l >= 0; l--) begin
            t[node] = ~way[l];
            node    = (node << 1) | WAYW'(way[l]);
        end
        return t;
    endfunction

    function automatic logic [WAYW-1:0] plru_victim(input logic [NWAY-1:0] tree);
        logic [WAYW-1:0] node;
        logic [WAYW-1:0] way;
        node = WAYW'(1);
        way  = '0;
        for (int l = WAYW - 1; l >= 0; l--) begin
            way[l] = tree[node];
            node   = (node << 1) | WAYW'(tree[node]);
        end
        return way;
    endfunction

    function automatic logic [SCNT-1:0] sat_inc(input logic [SCNT-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [SETW-1:0] lk_set, ins_set, inv_set;
    logic [STAG-1:0] lk_tag, ins_tag, inv_tag;
    assign lk_set  = lookup_va[SPAGE +: SETW];
    assign lk_tag  = lookup_va[SPAGE + SETW +: STAG];
    assign ins_set = insert_va[SPAGE +: SETW];
    assign ins_tag = insert_va[SPAGE + SETW +: STAG];
    assign inv_set = inv_va[SPAGE +: SETW];
    assign inv_tag = inv_va[SPAGE + SETW +: STAG];

    logic unused_offsets;
    assign unused_offsets = ^{insert_va[SPAGE-1:0], insert_pa[SPAGE-1:0], inv_va[SPAGE-1:0]};

    logic lk_acc, ins_acc, inv_acc;
    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == WALK);
    assign lk_acc  = lookup_valid && ready;
    assign inv_acc = inv_valid && ready;
    assign ins_acc = insert_valid && ready && !inv_valid;

    // Lookup compare: lowest matching way wins.
    logic            lk_hit;
    logic [WAYW-1:0] lk_way;
    logic [SVPN-1:0] lk_ppn;
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        lk_ppn = '0;
        for (int w = NWAY - 1; w >= 0; w--) begin
            if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag &&
                (glob_q[lk_set][w] || pcid_q[lk_set][w] == lookup_pcid)) begin
                lk_hit = 1'b1;
                lk_way = WAYW'(w);
                lk_ppn = ppn_q[lk_set][w];
            end
        end
    end

    // Insert target: in-place overwrite, else lowest free way, else PLRU victim.
    // A same-set lookup hit is folded into the tree before the insert touch.
    logic            ins_found, ins_free;
    logic [WAYW-1:0] ins_fway, ins_frway, ins_way;
    logic [NWAY-1:0] plru_base, ins_plru;
    always_comb begin
        ins_found = 1'b0;
        ins_free  = 1'b0;
        ins_fway  = '0;
        ins_frway = '0;
        for (int w = NWAY - 1; w >= 0; w--) begin
            if (valid_q[ins_set][w] && tag_q[ins_set][w] == ins_tag &&
                glob_q[ins_set][w] == insert_global &&
                (glob_q[ins_set][w] || pcid_q[ins_set][w] == insert_pcid)) begin
                ins_found = 1'b1;
                ins_fway  = WAYW'(w);
            end
            if (!valid_q[ins_set][w]) begin
                ins_free  = 1'b1;
                ins_frway = WAYW'(w);
            end
        end
        ins_way   = ins_found ? ins_fway : (ins_free ? ins_frway : plru_victim(plru_q[ins_set]));
        plru_base = (lk_acc && lk_hit && lk_set == ins_set) ? plru_touch(plru_q[ins_set], lk_way)
                                                             : plru_q[ins_set];
        ins_plru  = plru_touch(plru_base, ins_way);
    end

    always_comb begin
        state_d    = state_q;
        walk_cnt_d = walk_cnt_q;
        case (state_q)
            IDLE: begin
                if (inv_acc && inv_mode == 2'b01) begin
                    state_d    = WALK;
                    walk_cnt_d = '0;
                end
            end
            WALK: begin
                walk_cnt_d = walk_cnt_q + 1'b1;
                if (walk_cnt_q == SETW'(NSET - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge shutdown_n) begin
        if (!shutdown_n) begin
            state_q    <= IDLE;
            walk_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            walk_cnt_q <= walk_cnt_d;
        end
    end

    // Response stage: registered lookup result, counters, valid bits and PLRU.
    always_ff @(posedge clk or negedge shutdown_n) begin
        if (!shutdown_n) begin
            for (int s = 0; s < NSET; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_pa    <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            resp_valid <= lk_acc;
            resp_hit   <= lk_acc && lk_hit;
            resp_pa    <= (lk_acc && lk_hit) ? {lk_ppn, lookup_va[SPAGE-1:0]} : '0;
            if (lk_acc) begin
                if (lk_hit) begin
                    hit_cnt        <= sat_inc(hit_cnt);
                    plru_q[lk_set] <= plru_touch(plru_q[lk_set], lk_way);
                end else begin
                    miss_cnt <= sat_inc(miss_cnt);
                end
            end
            if (ins_acc) begin
                valid_q[ins_set][ins_way] <= 1'b1;
                plru_q[ins_set]           <= ins_plru;
            end
            if (inv_acc) begin
                case (inv_mode)
                    2'b00: for (int s = 0; s < NSET; s++) valid_q[s] <= '0;
                    2'b10: begin
                        for (int w = 0; w < NWAY; w++)
                            if (tag_q[inv_set][w] == inv_tag &&
                                (glob_q[inv_set][w] || pcid_q[inv_set][w] == inv_pcid))
                                valid_q[inv_set][w] <= 1'b0;
                    end
                    2'b11: begin
                        for (int w = 0; w < NWAY; w++)
                            if (tag_q[inv_set][w] == inv_tag) valid_q[inv_set][w] <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (state_q == WALK) begin
                for (int w = 0; w < NWAY; w++)
                    if (!glob_q[walk_cnt_q][w] && pcid_q[walk_cnt_q][w] == walk_pcid_q)
                        valid_q[walk_cnt_q][w] <= 1'b0;
            end
        end
    end

    // Entry payload: only qualified by valid bits, so it carries no reset.
    always_ff @(posedge clk) begin
        if (ins_acc) begin
            tag_q[ins_set][ins_way]  <= ins_tag;
            ppn_q[ins_set][ins_way]  <= insert_pa[SADDR-1:SPAGE];
            pcid_q[ins_set][ins_way] <= insert_pcid;
            glob_q[ins_set][ins_way] <= insert_global;
        end
        if (inv_acc && inv_mode == 2'b01) walk_pcid_q <= inv_pcid;
    end
endmodule

// File: tb/tb_pcid_tlb.sv
// tb_pcid_tlb: directed bench for pcid_tlb with default parameters
// (64-bit VA/PA, 4 KiB pages, 8 sets x 8 ways, 12-bit PCID, 32-bit counters).
module tb_pcid_tlb;
    logic        clk = 1'b0;
    logic        shutdown_n;
    logic        ready, busy;
    logic        lookup_valid;
    logic [63:0] lookup_va;
    logic [11:0] lookup_pcid;
    logic        resp_valid, resp_hit;
    logic [63:0] resp_pa;
    logic        insert_valid, insert_global;
    logic [63:0] insert_va, insert_pa;
    logic [11:0] insert_pcid;
    logic        inv_valid;
    logic [1:0]  inv_mode;
    logic [63:0] inv_va;
    logic [11:0] inv_pcid;
    logic [31:0] hit_cnt, miss_cnt;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [63:0] X = 64'hFFFF_FFFF_FFFF_FFF1;

    pcid_tlb dut (
        .clk(clk), .shutdown_n(shutdown_n), .ready(ready),
        .lookup_valid(lookup_valid), .lookup_va(lookup_va), .lookup_pcid(lookup_pcid),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_pa(resp_pa),
        .insert_valid(insert_valid), .insert_va(insert_va), .insert_pa(insert_pa),
        .insert_pcid(insert_pcid), .insert_global(insert_global),
        .inv_valid(inv_valid), .inv_mode(inv_mode), .inv_va(inv_va), .inv_pcid(inv_pcid),
        .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        shutdown_n = 1'b0;
        @(negedge clk);
        shutdown_n = 1'b1;
    endtask

    task automatic lookup(input logic [63:0] va, input logic [11:0] pcid,
                          input logic exp_hit, input logic [63:0] exp_pa, input string tag);
        lookup_va    = va;
        lookup_pcid  = pcid;
        lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        check({tag, ".valid"}, 64'(resp_valid), 64'd1);
        check({tag, ".hit"}, 64'(resp_hit), 64'(exp_hit));
        check({tag, ".pa"}, resp_pa, exp_pa);
    endtask

    task automatic insert(input logic [63:0] va, input logic [63:0] pa,
                          input logic [11:0] pcid, input logic glob);
        insert_va     = va;
        insert_pa     = pa;
        insert_pcid   = pcid;
        insert_global = glob;
        insert_valid  = 1'b1;
        tick();
        insert_valid  = 1'b0;
    endtask

    task automatic inv(input logic [1:0] mode, input logic [63:0] va, input logic [11:0] pcid);
        inv_mode  = mode;
        inv_va    = va;
        inv_pcid  = pcid;
        inv_valid = 1'b1;
        tick();
        inv_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        shutdown_n = 1'b0;
        lookup_valid = 1'b0; lookup_va = '0; lookup_pcid = '0;
        insert_valid = 1'b0; insert_va = '0; insert_pa = '0; insert_pcid = '0; insert_global = 1'b0;
        inv_valid = 1'b0; inv_mode = 2'b00; inv_va = '0; inv_pcid = '0;
        do_reset();

        // Reset state
        check("rst.ready", 64'(ready), 64'd1);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.resp_valid", 64'(resp_valid), 64'd0);
        check("rst.resp_hit", 64'(resp_hit), 64'd0);
        check("rst.resp_pa", resp_pa, 64'd0);
        check("rst.hit_cnt", 64'(hit_cnt), 64'd0);
        check("rst.miss_cnt", 64'(miss_cnt), 64'd0);

        // Cold miss, one-cycle response pulse
        lookup(X, 12'd0, 1'b0, 64'd0, "t1");
        check("t1.miss_cnt", 64'(miss_cnt), 64'd1);
        check("t1.hit_cnt", 64'(hit_cnt), 64'd0);
        tick();
        check("t1.pulse", 64'(resp_valid), 64'd0);

        // Insert then hit; other PCID misses
        do_reset();
        insert(X, 64'h1234_5000, 12'd0, 1'b0);
        lookup(X, 12'd0, 1'b1, 64'h1234_5FF1, "t2.p0");
        lookup(X, 12'd1, 1'b0, 64'd0, "t2.p1");
        check("t2.hit_cnt", 64'(hit_cnt), 64'd1);
        check("t2.miss_cnt", 64'(miss_cnt), 64'd1);

        // Global entry survives PCID walk; walk holds busy for 8 cycles
        insert(X, 64'hABC0_0000, 12'd0, 1'b1);
        inv(2'b01, 64'd0, 12'd0);
        for (int i = 0; i < 8; i++) begin
            check("t3.busy", 64'(busy), 64'd1);
            check("t3.ready", 64'(ready), 64'd0);
            if (i == 3) check("t3.ignored", 64'(resp_valid), 64'd0);
            lookup_valid = (i == 2);
            lookup_va    = X;
            lookup_pcid  = 12'd0;
            tick();
            lookup_valid = 1'b0;
        end
        check("t3.busy_end", 64'(busy), 64'd0);
        check("t3.ready_end", 64'(ready), 64'd1);
        check("t3.cnt_hold", 64'(hit_cnt), 64'd1);
        lookup(X, 12'd0, 1'b1, 64'hABC0_0FF1, "t3.p0");
        lookup(X, 12'd5, 1'b1, 64'hABC0_0FF1, "t3.p5");
        check("t3.hit_cnt", 64'(hit_cnt), 64'd3);
        check("t3.miss_cnt", 64'(miss_cnt), 64'd1);

        // Fill set 7, ninth tag evicts way 0
        do_reset();
        for (int k = 1; k <= 9; k++)
            insert((64'(k) << 15) | 64'h7000, 64'(k) << 20, 12'd3, 1'b0);
        lookup((64'd1 << 15) | 64'h7123, 12'd3, 1'b0, 64'd0, "t4.k1");
        for (int k = 2; k <= 9; k++)
            lookup((64'(k) << 15) | 64'h7123, 12'd3, 1'b1, (64'(k) << 20) | 64'h123, "t4.k");

        // Same-edge lookup + insert, then same-edge inv-all + insert
        lookup_va = 64'h5000; lookup_pcid = 12'd3; lookup_valid = 1'b1;
        insert(64'h5000, 64'h0CAF_E000, 12'd3, 1'b0);
        lookup_valid = 1'b0;
        check("t5.same_valid", 64'(resp_valid), 64'd1);
        check("t5.same_hit", 64'(resp_hit), 64'd0);
        lookup(64'h5000, 12'd3, 1'b1, 64'h0CAF_E000, "t5.after");
        inv_mode = 2'b00; inv_valid = 1'b1;
        insert(64'h6000, 64'hD000, 12'd3, 1'b0);
        inv_valid = 1'b0;
        lookup(64'h6000, 12'd3, 1'b0, 64'd0, "t5.dropped");
        lookup(64'h5000, 12'd3, 1'b0, 64'd0, "t5.clr_y");
        lookup((64'd9 << 15) | 64'h7123, 12'd3, 1'b0, 64'd0, "t5.clr_k9");

        // In-place overwrite, mode 10 and mode 11
        insert(64'h4_2ABC, 64'h7000, 12'd1, 1'b0);
        insert(64'h4_2ABC, 64'h8000, 12'd2, 1'b0);
        insert(64'h4_2ABC, 64'h9000, 12'd2, 1'b0);
        lookup(64'h4_2ABC, 12'd2, 1'b1, 64'h9ABC, "t6.ovw");
        lookup(64'h4_2ABC, 12'd1, 1'b1, 64'h7ABC, "t6.p1");
        inv(2'b10, 64'h4_2000, 12'd1);
        lookup(64'h4_2ABC, 12'd1, 1'b0, 64'd0, "t6.m10_p1");
        lookup(64'h4_2ABC, 12'd2, 1'b1, 64'h9ABC, "t6.m10_p2");
        inv(2'b11, 64'h4_2000, 12'd0);
        lookup(64'h4_2ABC, 12'd2, 1'b0, 64'd0, "t6.m11_p2");

        // Reset in cycle 3 of a walk
        insert(64'h3000, 64'h4000, 12'd4, 1'b0);
        inv(2'b01, 64'd0, 12'd4);
        tick();
        tick();
        check("t7.busy_pre", 64'(busy), 64'd1);
        #2;
        shutdown_n = 1'b0;
        #1;
        check("t7.busy", 64'(busy), 64'd0);
        check("t7.ready", 64'(ready), 64'd1);
        check("t7.hit_cnt", 64'(hit_cnt), 64'd0);
        check("t7.miss_cnt", 64'(miss_cnt), 64'd0);
        check("t7.resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        shutdown_n = 1'b1;
        lookup(64'h3000, 12'd4, 1'b0, 64'd0, "t7.cleared");
        check("t7.busy_post", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
